fp32_add_bridge: RTL and testbench

Initiator-side bridge between the pipeline's valid/ready streams and the FP32 adder core's stb/ack port set.
- Accepts one operand pair from upstream and drives the core's `input_a`/`input_b` strobes until each is acknowledged.
- Acknowledges the core's `output_z` strobe and presents the sum downstream with valid/ready.
- Sits between the operand source and the adder core, replacing direct strobe tie-offs.
- Adds per-operation timeout detection and a completed-operation counter.

---
 rtl/fp32_pkg.sv | 20 ++
 rtl/fp32_add_bridge_if.sv | 42 ++++
 rtl/fp32_stb_ack_tx.sv | 51 +++++
 rtl/fp32_add_bridge.sv | 117 +++++++++++
 tb/tb_fp32_add_bridge.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 types, bridge FSM state encoding and reference constants.
package fp32_pkg;

   localparam int unsigned FP32_W = 32;

   typedef logic [FP32_W-1:0] fp32_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      WAIT_Z = 2'd2,
      HOLD   = 2'd3
   } bridge_state_e;

   localparam fp32_t FP32_ONE   = 32'h3F80_0000;
   localparam fp32_t FP32_TWO   = 32'h4000_0000;
   localparam fp32_t FP32_THREE = 32'h4040_0000;
   localparam fp32_t FP32_FOUR  = 32'h4080_0000;

endpackage

// File: rtl/fp32_add_bridge_if.sv
// Stream-side and core-side signal bundle of the FP32 adder bridge.
interface fp32_add_bridge_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) ();

   logic              valid_i;
   logic              ready_o;
   logic [DATA_W-1:0] a_i;
   logic [DATA_W-1:0] b_i;
   logic [DATA_W-1:0] core_a_o;
   logic [DATA_W-1:0] core_b_o;
   logic              core_a_stb_o;
   logic              core_b_stb_o;
   logic              core_a_ack_i;
   logic              core_b_ack_i;
   logic [DATA_W-1:0] core_z_i;
   logic              core_z_stb_i;
   logic              core_z_ack_o;
   logic [DATA_W-1:0] z_o;
   logic              valid_o;
   logic              ready_i;
   logic              err_o;
   logic [CNT_W-1:0]  done_cnt_o;

   // Bridge side
   modport master (
      input  valid_i, a_i, b_i, core_a_ack_i, core_b_ack_i,
             core_z_i, core_z_stb_i, ready_i,
      output ready_o, core_a_o, core_b_o, core_a_stb_o, core_b_stb_o,
             core_z_ack_o, z_o, valid_o, err_o, done_cnt_o
   );

   // Environment side (operand source, adder core, result sink)
   modport slave (
      output valid_i, a_i, b_i, core_a_ack_i, core_b_ack_i,
             core_z_i, core_z_stb_i, ready_i,
      input  ready_o, core_a_o, core_b_o, core_a_stb_o, core_b_stb_o,
             core_z_ack_o, z_o, valid_o, err_o, done_cnt_o
   );

endinterface

// File: rtl/fp32_stb_ack_tx.sv
// One operand channel toward the core: holds the operand and raises its
// strobe until the core acknowledges it.
module fp32_stb_ack_tx #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              ack_i,
   output logic [DATA_W-1:0] data_o,
   output logic              stb_o,
   output logic              done_o,
   output logic              xfer_c
);

   logic [DATA_W-1:0] data_q, data_d;
   logic              stb_q, stb_d;

   // Transfer happens when an ack is seen while the strobe is up; acks
   // arriving with the strobe low are ignored.
   assign xfer_c = stb_q & ack_i;

   // Next-state for operand register and strobe flag
   always_comb begin
      data_d = data_q;
      stb_d  = stb_q;
      if (load_i) begin
         data_d = data_i;
         stb_d  = 1'b1;
      end else if (xfer_c) begin
         stb_d  = 1'b0;
      end
   end

   // Operand and strobe registers
   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         data_q <= '0;
         stb_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         stb_q  <= stb_d;
      end
   end

   assign data_o = data_q;
   assign stb_o  = stb_q;
   assign done_o = ~stb_q;

endmodule

// File: rtl/fp32_add_bridge.sv
// Valid/ready to stb/ack bridge in front of a serial FP32 adder core, with
// sticky per-operation timeout and a wrapping completion counter.
module fp32_add_bridge
   import fp32_pkg::*;
#(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 16
) (
   input logic               clk,
   input logic               srst,
   fp32_add_bridge_if.master br_if
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   bridge_state_e     state_q;
   logic              accept_c;
   logic              both_sent_c;
   logic              a_done, b_done;
   logic              a_xfer_c, b_xfer_c;
   logic              busy_c;
   logic [DATA_W-1:0] z_q, z_d;
   logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              err_q, err_d;

   assign accept_c    = (state_q == IDLE) & br_if.valid_i;
   assign both_sent_c = (a_done | a_xfer_c) & (b_done | b_xfer_c);
   assign busy_c      = (state_q == SEND) | (state_q == WAIT_Z);

   fp32_stb_ack_tx #(.DATA_W(DATA_W)) u_tx_a (
      .clk    (clk),
      .srst   (srst),
      .load_i (accept_c),
      .data_i (br_if.a_i),
      .ack_i  (br_if.core_a_ack_i),
      .data_o (br_if.core_a_o),
      .stb_o  (br_if.core_a_stb_o),
      .done_o (a_done),
      .xfer_c (a_xfer_c)
   );

   fp32_stb_ack_tx #(.DATA_W(DATA_W)) u_tx_b (
      .clk    (clk),
      .srst   (srst),
      .load_i (accept_c),
      .data_i (br_if.b_i),
      .ack_i  (br_if.core_b_ack_i),
      .data_o (br_if.core_b_o),
      .stb_o  (br_if.core_b_stb_o),
      .done_o (b_done),
      .xfer_c (b_xfer_c)
   );

   // Operation sequencing: accept, push operands, collect result, hand off
   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE:    if (accept_c)           state_q <= SEND;
            SEND:    if (both_sent_c)        state_q <= WAIT_Z;
            WAIT_Z:  if (br_if.core_z_stb_i) state_q <= HOLD;
            HOLD:    if (br_if.ready_i)      state_q <= IDLE;
            default:                         state_q <= IDLE;
         endcase
      end
   end

   // Next-state for result, completion count and timeout tracking
   always_comb begin
      z_d        = z_q;
      done_cnt_d = done_cnt_q;
      tmo_d      = tmo_q;
      err_d      = err_q;
      if ((state_q == WAIT_Z) && br_if.core_z_stb_i) begin
         z_d = br_if.core_z_i;
      end
      if ((state_q == HOLD) && br_if.ready_i) begin
         done_cnt_d = done_cnt_q + CNT_W'(1);
      end
      if (accept_c) begin
         tmo_d = '0;
      end else if (busy_c && (tmo_q != TMO_W'(TIMEOUT_CYCLES))) begin
         tmo_d = tmo_q + TMO_W'(1);
      end
      // Sticky: the operation keeps waiting, only the flag reports it.
      if (tmo_d == TMO_W'(TIMEOUT_CYCLES)) begin
         err_d = 1'b1;
      end
   end

   // Result, counter and error registers
   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         z_q        <= '0;
         done_cnt_q <= '0;
         tmo_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         z_q        <= z_d;
         done_cnt_q <= done_cnt_d;
         tmo_q      <= tmo_d;
         err_q      <= err_d;
      end
   end

   // Handshake outputs decoded from the state register only
   assign br_if.ready_o      = (state_q == IDLE);
   assign br_if.core_z_ack_o = (state_q == WAIT_Z);
   assign br_if.valid_o      = (state_q == HOLD);
   assign br_if.z_o          = z_q;
   assign br_if.err_o        = err_q;
   assign br_if.done_cnt_o   = done_cnt_q;

endmodule

// File: tb/tb_fp32_add_bridge.sv
// Directed bench for fp32_add_bridge with a small stb/ack adder-core model.
module tb_fp32_add_bridge;
   import fp32_pkg::*;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned TMO    = 8;
   localparam int unsigned CNT_W  = 2;

   logic clk;
   logic srst;

   fp32_add_bridge_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   fp32_add_bridge #(
      .DATA_W         (DATA_W),
      .TIMEOUT_CYCLES (TMO),
      .CNT_W          (CNT_W)
   ) dut (
      .clk   (clk),
      .srst  (srst),
      .br_if (bus)
   );

   int checks   = 0;
   int failures = 0;
   logic [CNT_W-1:0] cnt_exp;

   // Core model knobs and state
   int    a_lat   = 1;
   int    b_lat   = 1;
   int    z_lat   = 1;
   bit    z_never = 1'b0;
   bit    spur    = 1'b0;
   int    a_cnt   = 0;
   int    b_cnt   = 0;
   int    z_cnt   = 0;
   fp32_t a_seen  = '0;
   fp32_t b_seen  = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-tabulated sums for the operand pairs used here
   function automatic fp32_t core_sum(fp32_t a, fp32_t b);
      if ((a == FP32_ONE && b == FP32_TWO) || (a == FP32_TWO && b == FP32_ONE)) return FP32_THREE;
      if (a == FP32_TWO && b == FP32_TWO) return FP32_FOUR;
      if (a == FP32_ONE && b == FP32_ONE) return FP32_TWO;
      return 32'hDEAD_BEEF;
   endfunction

   // Adder core model: acks each strobe after its latency, returns the sum
   always @(negedge clk) begin
      if (spur) begin
         bus.core_a_ack_i = 1'b1;
         bus.core_b_ack_i = 1'b1;
         bus.core_z_stb_i = 1'b1;
         bus.core_z_i     = 32'hBAD0_0BAD;
      end else begin
         if (bus.core_a_stb_o) begin a_cnt++; a_seen = bus.core_a_o; end else a_cnt = 0;
         if (bus.core_b_stb_o) begin b_cnt++; b_seen = bus.core_b_o; end else b_cnt = 0;
         if (bus.core_z_ack_o) z_cnt++; else z_cnt = 0;
         bus.core_a_ack_i = bus.core_a_stb_o && (a_cnt == a_lat);
         bus.core_b_ack_i = bus.core_b_stb_o && (b_cnt == b_lat);
         bus.core_z_stb_i = bus.core_z_ack_o && !z_never && (z_cnt >= z_lat);
         bus.core_z_i     = core_sum(a_seen, b_seen);
      end
   end

   task automatic send_pair(input fp32_t a, input fp32_t b);
      @(negedge clk);
      bus.a_i     = a;
      bus.b_i     = b;
      bus.valid_i = 1'b1;
      @(posedge clk);
      #1 bus.valid_i = 1'b0;
   endtask

   task automatic wait_valid(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (bus.valid_o) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset;
      logic [5:0] obs;
      srst = 1'b1;
      @(negedge clk);
      obs = {bus.ready_o, bus.valid_o, bus.core_a_stb_o, bus.core_b_stb_o, bus.core_z_ack_o, bus.err_o};
      checks++;
      if (obs !== 6'b100000) begin failures++; $display("FAIL reset_flags: got %b expected 100000", obs); end
      checks++;
      if ({bus.z_o, bus.core_a_o, bus.core_b_o} !== 96'd0) begin
         failures++; $display("FAIL reset_data: z=%h a=%h b=%h expected 0", bus.z_o, bus.core_a_o, bus.core_b_o);
      end
      checks++;
      if (bus.done_cnt_o !== 2'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", bus.done_cnt_o); end
      @(negedge clk);
      srst    = 1'b0;
      cnt_exp = '0;
   endtask

   task automatic test_basic;
      a_lat = 1; b_lat = 1; z_lat = 1; bus.ready_i = 1'b1;
      send_pair(FP32_ONE, FP32_TWO);
      @(negedge clk);
      checks++;
      if ({bus.core_a_stb_o, bus.core_b_stb_o, bus.ready_o} !== 3'b110) begin
         failures++; $display("FAIL basic_strobes: got %b expected 110", {bus.core_a_stb_o, bus.core_b_stb_o, bus.ready_o});
      end
      checks++;
      if ({bus.core_a_o, bus.core_b_o} !== {FP32_ONE, FP32_TWO}) begin
         failures++; $display("FAIL basic_operands: got %h %h expected %h %h", bus.core_a_o, bus.core_b_o, FP32_ONE, FP32_TWO);
      end
      @(negedge clk);
      checks++;
      if ({bus.core_z_ack_o, bus.valid_o} !== 2'b10) begin
         failures++; $display("FAIL basic_wait_z: got %b expected 10", {bus.core_z_ack_o, bus.valid_o});
      end
      @(negedge clk);
      checks++;
      if (bus.valid_o !== 1'b1 || bus.z_o !== FP32_THREE) begin
         failures++; $display("FAIL basic_result: valid=%b z=%h expected 1 %h", bus.valid_o, bus.z_o, FP32_THREE);
      end
      cnt_exp++;
      @(negedge clk);
      checks++;
      if ({bus.valid_o, bus.ready_o} !== 2'b01 || bus.done_cnt_o !== cnt_exp) begin
         failures++; $display("FAIL basic_done: valid=%b ready=%b cnt=%0d expected 0 1 %0d", bus.valid_o, bus.ready_o, bus.done_cnt_o, cnt_exp);
      end
   endtask

   task automatic test_ack_order;
      bit ok;
      logic [2:0] exp_v;
      a_lat = 5; b_lat = 2; z_lat = 2;
      send_pair(FP32_TWO, FP32_ONE);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         exp_v = {c <= 5, c <= 2, c == 6};
         checks++;
         if ({bus.core_a_stb_o, bus.core_b_stb_o, bus.core_z_ack_o} !== exp_v) begin
            failures++; $display("FAIL ack_order_c%0d: got %b expected %b", c, {bus.core_a_stb_o, bus.core_b_stb_o, bus.core_z_ack_o}, exp_v);
         end
      end
      wait_valid(10, ok);
      checks++;
      if (!ok || bus.z_o !== FP32_THREE) begin failures++; $display("FAIL ack_order_result: ok=%b z=%h expected %h", ok, bus.z_o, FP32_THREE); end
      cnt_exp++;
      @(negedge clk);
      a_lat = 1; b_lat = 1; z_lat = 1;
   endtask

   task automatic test_backpressure;
      bit ok;
      bus.ready_i = 1'b0;
      send_pair(FP32_ONE, FP32_ONE);
      wait_valid(10, ok);
      checks++;
      if (!ok || bus.z_o !== FP32_TWO) begin failures++; $display("FAIL bp_result: ok=%b z=%h expected %h", ok, bus.z_o, FP32_TWO); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.valid_o, bus.ready_o} !== 2'b10 || bus.z_o !== FP32_TWO || bus.done_cnt_o !== cnt_exp) begin
            failures++; $display("FAIL bp_hold_%0d: valid=%b ready=%b z=%h cnt=%0d expected 1 0 %h %0d", i, bus.valid_o, bus.ready_o, bus.z_o, bus.done_cnt_o, FP32_TWO, cnt_exp);
         end
      end
      bus.ready_i = 1'b1;
      cnt_exp++;
      @(posedge clk);
      #1;
      checks++;
      if ({bus.valid_o, bus.ready_o} !== 2'b01 || bus.done_cnt_o !== cnt_exp) begin
         failures++; $display("FAIL bp_release: valid=%b ready=%b cnt=%0d expected 0 1 %0d", bus.valid_o, bus.ready_o, bus.done_cnt_o, cnt_exp);
      end
   endtask

   task automatic test_spurious;
      spur = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.ready_o, bus.valid_o, bus.core_a_stb_o, bus.core_b_stb_o, bus.core_z_ack_o} !== 5'b10000 || bus.z_o !== FP32_TWO) begin
            failures++; $display("FAIL spurious_%0d: flags=%b z=%h expected 10000 %h", i,
               {bus.ready_o, bus.valid_o, bus.core_a_stb_o, bus.core_b_stb_o, bus.core_z_ack_o}, bus.z_o, FP32_TWO);
         end
      end
      spur = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      bit ok;
      @(negedge clk);
      bus.a_i = FP32_ONE; bus.b_i = FP32_TWO; bus.valid_i = 1'b1;
      wait_valid(10, ok);
      checks++;
      if (!ok || bus.z_o !== FP32_THREE || bus.ready_o !== 1'b0) begin
         failures++; $display("FAIL b2b_first: ok=%b z=%h ready=%b expected %h 0", ok, bus.z_o, bus.ready_o, FP32_THREE);
      end
      cnt_exp++;
      @(negedge clk);
      checks++;
      if ({bus.ready_o, bus.valid_o} !== 2'b10 || bus.done_cnt_o !== cnt_exp) begin
         failures++; $display("FAIL b2b_idle: ready=%b valid=%b cnt=%0d expected 1 0 %0d", bus.ready_o, bus.valid_o, bus.done_cnt_o, cnt_exp);
      end
      bus.a_i = FP32_TWO; bus.b_i = FP32_TWO;
      @(posedge clk);
      #1 bus.valid_i = 1'b0;
      checks++;
      if (bus.ready_o !== 1'b0 || bus.core_a_stb_o !== 1'b1) begin
         failures++; $display("FAIL b2b_second_accept: ready=%b stb=%b expected 0 1", bus.ready_o, bus.core_a_stb_o);
      end
      wait_valid(10, ok);
      checks++;
      if (!ok || bus.z_o !== FP32_FOUR) begin failures++; $display("FAIL b2b_second: ok=%b z=%h expected %h", ok, bus.z_o, FP32_FOUR); end
      cnt_exp++;
      @(negedge clk);
   endtask

   task automatic test_timeout;
      bit ok;
      checks++;
      if (bus.err_o !== 1'b0) begin failures++; $display("FAIL tmo_pre: err=%b expected 0", bus.err_o); end
      z_never = 1'b1;
      send_pair(FP32_ONE, FP32_TWO);
      for (int k = 1; k <= 11; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus.err_o !== (k >= 8)) begin failures++; $display("FAIL tmo_edge_%0d: err=%b expected %b", k, bus.err_o, k >= 8); end
      end
      z_never = 1'b0;
      wait_valid(10, ok);
      checks++;
      if (!ok || bus.z_o !== FP32_THREE || bus.err_o !== 1'b1) begin
         failures++; $display("FAIL tmo_late: ok=%b z=%h err=%b expected %h 1", ok, bus.z_o, bus.err_o, FP32_THREE);
      end
      cnt_exp++;
      @(negedge clk);
      checks++;
      if (bus.done_cnt_o !== cnt_exp || bus.err_o !== 1'b1) begin
         failures++; $display("FAIL tmo_done: cnt=%0d err=%b expected %0d 1", bus.done_cnt_o, bus.err_o, cnt_exp);
      end
   endtask

   task automatic test_reset_mid;
      bit ok;
      logic [5:0] obs;
      z_never = 1'b1;
      send_pair(FP32_ONE, FP32_ONE);
      repeat (3) @(negedge clk);
      checks++;
      if (bus.core_z_ack_o !== 1'b1) begin failures++; $display("FAIL rmid_wait_z: ack=%b expected 1", bus.core_z_ack_o); end
      @(posedge clk);
      #2 srst = 1'b1;
      #1;
      obs = {bus.ready_o, bus.valid_o, bus.core_a_stb_o, bus.core_b_stb_o, bus.core_z_ack_o, bus.err_o};
      checks++;
      if (obs !== 6'b100000 || bus.done_cnt_o !== 2'd0 || {bus.z_o, bus.core_a_o, bus.core_b_o} !== 96'd0) begin
         failures++; $display("FAIL rmid_async: flags=%b cnt=%0d z=%h a=%h b=%h expected 100000 0 0 0 0",
            obs, bus.done_cnt_o, bus.z_o, bus.core_a_o, bus.core_b_o);
      end
      @(negedge clk);
      srst = 1'b0; z_never = 1'b0; cnt_exp = '0;
      send_pair(FP32_TWO, FP32_TWO);
      wait_valid(10, ok);
      checks++;
      if (!ok || bus.z_o !== FP32_FOUR) begin failures++; $display("FAIL rmid_next: ok=%b z=%h expected %h", ok, bus.z_o, FP32_FOUR); end
      @(negedge clk);
      checks++;
      if (bus.done_cnt_o !== 2'd1) begin failures++; $display("FAIL rmid_cnt: got %0d expected 1", bus.done_cnt_o); end
   endtask

   task automatic test_wrap;
      bit ok;
      int seq [5] = '{1, 2, 3, 0, 1};
      srst = 1'b1;
      @(negedge clk);
      srst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i % 2 == 0) send_pair(FP32_ONE, FP32_ONE); else send_pair(FP32_TWO, FP32_ONE);
         wait_valid(10, ok);
         checks++;
         if (!ok || bus.z_o !== ((i % 2 == 0) ? FP32_TWO : FP32_THREE)) begin
            failures++; $display("FAIL wrap_result_%0d: ok=%b z=%h", i, ok, bus.z_o);
         end
         @(negedge clk);
         checks++;
         if (bus.done_cnt_o !== 2'(seq[i])) begin failures++; $display("FAIL wrap_cnt_%0d: got %0d expected %0d", i, bus.done_cnt_o, seq[i]); end
      end
   endtask

   initial begin
      srst        = 1'b1;
      bus.valid_i = 1'b0;
      bus.a_i     = '0;
      bus.b_i     = '0;
      bus.ready_i = 1'b1;
      cnt_exp     = '0;
      test_reset();
      test_basic();
      test_ack_order();
      test_backpressure();
      test_spurious();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
